// File: rtl/ide.sv
// ide -- single-transfer ATA/IDE PIO register access engine.
//
// Turns a held read or write request into one IDE bus cycle. The cycle has
// address/chip-select setup, then a DIOR-/DIOW- strobe pulse, then hold.
// After that it gives a one-cycle ata_done pulse.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   ata_rd, ata_wr  request inputs, held high until ata_done (read wins if both)
//   ata_addr[4:0]   [4] CS0 select, [3] CS1 select, [2:0] DA
//   ata_in[15:0]    write data
//   ata_out[15:0]   last read data, held until the next read completes
//   ata_done        one-cycle completion pulse
//   ide_data_bus    IDE data bus, driven only during a write cycle
//   ide_dior        DIOR-, active low
//   ide_diow        DIOW-, active low
//   ide_cs[1:0]     {CS1-, CS0-}, active low
//   ide_da[2:0]     device address
//
// State | meaning
// IDLE  | waiting for a request; latches direction, address and data
// SETUP | cs/da driven, strobes high, T_SETUP cycles
// PULSE | selected strobe low for T_PULSE cycles; read data sampled on last cycle
// HOLD  | strobes high, cs/da/data held for T_HOLD cycles
// DONE  | return to IDLE; ata_done is raised on the following cycle
module ide #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 8,
  parameter int T_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ata_rd,
  input  logic        ata_wr,
  input  logic [4:0]  ata_addr,
  input  logic [15:0] ata_in,
  output logic [15:0] ata_out,
  output logic        ata_done,
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Down-counter reload values. A phase lasts (reload + 1) cycles.
  // A zero parameter is stretched to one cycle.
  localparam logic [7:0] SETUP_LD = (T_SETUP < 2) ? 8'd0 : 8'(T_SETUP - 1);
  localparam logic [7:0] PULSE_LD = (T_PULSE < 2) ? 8'd0 : 8'(T_PULSE - 1);
  localparam logic [7:0] HOLD_LD  = (T_HOLD  < 2) ? 8'd0 : 8'(T_HOLD  - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_rd_q, is_rd_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    // ata_done is registered, so it rises on the cycle after DONE.
    // This gives the full T_SETUP+T_PULSE+T_HOLD+1 latency.
    done_d  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (ata_rd || ata_wr) begin
          is_rd_d = ata_rd;
          addr_d  = ata_addr;
          wdata_d = ata_in;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          // Capture on the same edge that releases DIOR-.
          if (is_rd_q) rdata_d = ide_data_bus;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      is_rd_q <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign active   = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
  assign ide_cs   = active ? {~addr_q[3], ~addr_q[4]} : 2'b11;
  assign ide_da   = active ? addr_q[2:0] : 3'd0;
  assign ide_dior = !((state_q == S_PULSE) && is_rd_q);
  assign ide_diow = !((state_q == S_PULSE) && !is_rd_q);
  assign ide_data_bus = (active && !is_rd_q) ? wdata_q : 16'hzzzz;
  assign ata_out  = rdata_q;
  assign ata_done = done_q;

endmodule

// File: tb/tb_ide.sv
module tb_ide;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ata_rd, ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out, ata_out0;
  logic        ata_done, ata_done0;
  logic        dior, diow, dior0, diow0;
  logic [1:0]  cs, cs0;
  logic [2:0]  da, da0;
  wire  [15:0] bus, bus0;
  logic [15:0] dev_val;
  logic        dev_force;

  // Device model: it drives read data while DIOR- is low. It can also be
  // forced on to show that the host has released the bus.
  assign bus  = (!dior || dev_force) ? dev_val : 16'hzzzz;
  assign bus0 = (!dior0) ? 16'hC3C3 : 16'hzzzz;

  ide dut (
    .clk(clk), .reset(reset), .ata_rd(ata_rd), .ata_wr(ata_wr),
    .ata_addr(ata_addr), .ata_in(ata_in), .ata_out(ata_out), .ata_done(ata_done),
    .ide_data_bus(bus), .ide_dior(dior), .ide_diow(diow), .ide_cs(cs), .ide_da(da)
  );

  ide #(.T_SETUP(0), .T_PULSE(0), .T_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .ata_rd(ata_rd), .ata_wr(ata_wr),
    .ata_addr(ata_addr), .ata_in(ata_in), .ata_out(ata_out0), .ata_done(ata_done0),
    .ide_data_bus(bus0), .ide_dior(dior0), .ide_diow(diow0), .ide_cs(cs0), .ide_da(da0)
  );

  int checks = 0;
  int failures = 0;

  // One full transfer; k is the cycle count after the IDLE sampling edge.
  task automatic do_xfer(input logic rd, input logic wr, input logic [4:0] addr,
                         input logic [15:0] din, input logic [15:0] dv,
                         input logic exp_read, input logic [1:0] exp_cs,
                         input logic [2:0] exp_da, input logic [15:0] exp_out,
                         input string name);
    logic [7:0] got, exp;
    @(posedge clk); #1;
    ata_rd = rd; ata_wr = wr; ata_addr = addr; ata_in = din; dev_val = dv;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        ata_addr = ~addr;
        ata_in   = ~din;
      end
      exp = {!(exp_read && k >= 2 && k <= 9), !(!exp_read && k >= 2 && k <= 9),
             (k <= 11) ? exp_cs : 2'b11, (k <= 11) ? exp_da : 3'd0, (k == 13)};
      got = {dior, diow, cs, da, ata_done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s k=%0d {dior,diow,cs,da,done} got=%b exp=%b", name, k, got, exp);
      end
      if (!exp_read && k <= 11) begin
        checks++;
        if (bus !== din) begin
          failures++;
          $display("FAIL %s_bus k=%0d got=%h exp=%h", name, k, bus, din);
        end
      end
      if (k == 13) begin
        ata_rd = 1'b0;
        ata_wr = 1'b0;
      end
    end
    checks++;
    if (ata_out !== exp_out) begin
      failures++;
      $display("FAIL %s_ata_out got=%h exp=%h", name, ata_out, exp_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ata_rd = 1'b0; ata_wr = 1'b0; ata_addr = 5'd0; ata_in = 16'd0;
    dev_val = 16'd0; dev_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ata_out, ata_done, dior, diow, cs, da} !== {16'd0, 1'b0, 1'b1, 1'b1, 2'b11, 3'd0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h %b %b %b %b %h", ata_out, ata_done, dior, diow, cs, da);
    end
    dev_force = 1'b1; dev_val = 16'hA5A5;
    #1;
    checks++;
    if (bus !== 16'hA5A5) begin
      failures++;
      $display("FAIL reset_bus_hiz got=%h exp=a5a5", bus);
    end
    dev_force = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read();
    do_xfer(1'b1, 1'b0, 5'b10111, 16'h9999, 16'h0050, 1'b1, 2'b10, 3'd7, 16'h0050, "read");
  endtask

  task automatic test_write();
    do_xfer(1'b0, 1'b1, 5'b10110, 16'h0040, 16'hFFFF, 1'b0, 2'b10, 3'd6, 16'h0050, "write");
  endtask

  task automatic test_alt_status();
    do_xfer(1'b1, 1'b0, 5'b01110, 16'h0000, 16'h00D0, 1'b1, 2'b01, 3'd6, 16'h00D0, "alt_status");
  endtask

  task automatic test_back_to_back();
    int ndone;
    ndone = 0;
    @(posedge clk); #1;
    ata_rd = 1'b1; ata_addr = 5'b10111; dev_val = 16'h1111;
    for (int k = 0; k <= 31; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ata_done !== (k == 13 || k == 27)) begin
        failures++;
        $display("FAIL b2b_done k=%0d got=%b exp=%b", k, ata_done, (k == 13 || k == 27));
      end
      if (ata_done) begin
        ndone++;
        if (ndone == 1) dev_val = 16'h2222;
        if (ndone == 2) ata_rd = 1'b0;
      end
    end
    ata_rd = 1'b0;
    checks++;
    if (ndone != 2) begin
      failures++;
      $display("FAIL b2b_pulse_count got=%0d exp=2", ndone);
    end
    checks++;
    if (ata_out !== 16'h2222) begin
      failures++;
      $display("FAIL b2b_ata_out got=%h exp=2222", ata_out);
    end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    ata_wr = 1'b1; ata_addr = 5'b10110; ata_in = 16'h5A5A;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (diow !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_pulse diow got=%b exp=0", diow);
    end
    reset = 1'b1; ata_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({dior, diow, cs, da, ata_done} !== {1'b1, 1'b1, 2'b11, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL abort_outputs got=%b %b %b %h %b", dior, diow, cs, da, ata_done);
    end
    dev_force = 1'b1; dev_val = 16'hA5A5;
    #1;
    checks++;
    if (bus !== 16'hA5A5) begin
      failures++;
      $display("FAIL abort_bus_hiz got=%h exp=a5a5", bus);
    end
    dev_force = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ata_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done k=%0d got=%b exp=0", k, ata_done);
      end
    end
    do_xfer(1'b1, 1'b1, 5'b10111, 16'h1234, 16'h0077, 1'b1, 2'b10, 3'd7, 16'h0077, "rd_wins");
  endtask

  task automatic test_zero_params();
    @(posedge clk); #1;
    ata_rd = 1'b1; ata_addr = 5'b10111;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({dior0, diow0, cs0, ata_done0} !== {!(k == 1), 1'b1, (k <= 2) ? 2'b10 : 2'b11, (k == 4)}) begin
        failures++;
        $display("FAIL zero_param k=%0d {dior,diow,cs,done} got=%b%b%b%b", k, dior0, diow0, cs0, ata_done0);
      end
      if (k == 4) ata_rd = 1'b0;
    end
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (ata_out0 !== 16'hC3C3) begin
      failures++;
      $display("FAIL zero_param_ata_out got=%h exp=c3c3", ata_out0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_alt_status();
    test_back_to_back();
    test_reset_abort();
    test_zero_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ide.md
IDE -- requirements
Module: ide

Interface
REQ-001 Parameter T_SETUP, default 2: clock cycles of address/chip-select setup before the strobe.
REQ-002 Parameter T_PULSE, default 8: clock cycles the DIOR-/DIOW- strobe is held low.
REQ-003 Parameter T_HOLD, default 2: clock cycles of address and data hold after the strobe is released.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 ata_rd  input  1  read request; held high by the requester until ata_done.
REQ-007 ata_wr  input  1  write request; held high by the requester until ata_done.
REQ-008 ata_addr  input  5  register address: [4] CS0 select, [3] CS1 select, [2:0] DA.
REQ-009 ata_in  input  16  write data.
REQ-010 ata_out  output  16  last read data; holds its value until the next read completes.
REQ-011 ata_done  output  1  one-cycle completion pulse.
REQ-012 ide_data_bus  inout  16  IDE data bus; high-Z unless a write cycle is in progress.
REQ-013 ide_dior  output  1  DIOR-, active low.
REQ-014 ide_diow  output  1  DIOW-, active low.
REQ-015 ide_cs  output  2  [0]=CS0-, [1]=CS1-, both active low.
REQ-016 ide_da  output  3  device address DA[2:0].

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD and DONE.
REQ-018 IDLE: on (ata_rd|ata_wr), latch the direction, ata_addr and ata_in, then go to SETUP. If both requests are high, the read SHALL win.
REQ-019 SETUP: ide_cs = {~addr[3], ~addr[4]} and ide_da = addr[2:0] are driven from the latched address; both strobes stay high for T_SETUP cycles; then go to PULSE.
REQ-020 PULSE: the selected strobe (ide_dior for a read, ide_diow for a write) is low for exactly T_PULSE cycles; then go to HOLD.
REQ-021 Read: ide_data_bus SHALL be sampled into ata_out on the last PULSE cycle, i.e. the edge on which the strobe deasserts.
REQ-022 Write: ide_data_bus SHALL drive the latched ata_in from SETUP entry through the end of HOLD, and is high-Z in all other states.
REQ-023 HOLD: strobes are high, address and cs are held for T_HOLD cycles; then go to DONE.
REQ-024 DONE: ata_done = 1 for exactly one cycle, then go to IDLE.
REQ-025 Requests present during DONE SHALL be ignored; a new request is sampled only in IDLE, so back-to-back transfers are allowed.
REQ-026 Latency SHALL be T_SETUP+T_PULSE+T_HOLD+1 cycles from the IDLE sampling edge to ata_done high (13 cycles with the defaults).
REQ-027 In IDLE and DONE: ide_cs = 2'b11, ide_da = 0, ide_dior = ide_diow = 1.
REQ-028 A write SHALL NOT modify ata_out.
REQ-029 Request inputs that change mid-transfer SHALL NOT affect the transfer in progress.
REQ-030 Timing counters SHALL be wide enough for any parameter value up to 255; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-031 When reset is high, the block SHALL go to IDLE on the next edge.
REQ-032 Reset state: ata_out = 0, ata_done = 0, ide_dior = ide_diow = 1, ide_cs = 2'b11, ide_da = 0, bus high-Z.
REQ-033 Reset during any state SHALL abort the transfer immediately, with no ata_done pulse.

Verification
REQ-034 Read, addr 5'b10111, device drives 16'h0050 -> cs=2'b10, da=7, dior low for 8 cycles, ata_out=16'h0050, ata_done 13 cycles after the request.
REQ-035 Write, addr 5'b10110, ata_in 16'h0040 -> bus=16'h0040 while diow is low, cs=2'b10, da=6, dior stays high, ata_out unchanged.
REQ-036 Read, addr 5'b01110 (alt status) -> cs=2'b01, da=6.
REQ-037 Back-to-back reads, ata_rd held high across ata_done -> two distinct transfers, two one-cycle ata_done pulses, ata_out = the second value.
REQ-038 Reset asserted in PULSE -> next cycle: strobes high, cs=2'b11, bus high-Z, no ata_done; ata_rd and ata_wr both high -> a read is performed.
